// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with bursts of up to BURST_LEN words.
// Optional per-requester accepted-word counters are enabled by defining FIFO_ARB_WORDCNT_EN.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Clear_in,
    input  logic [NREQ-1:0]      Req_in,
    input  logic [NREQ*DW-1:0]   Data_in,
    input  logic                 Full_in,
    output logic [NREQ-1:0]      Gnt_out,
    output logic [NREQ-1:0]      Ack_out,
    output logic                 WriteEn_out,
    output logic [DW-1:0]        Data_out,
    output logic                 Busy_out
`ifdef FIFO_ARB_WORDCNT_EN
    ,
    output logic [NREQ*8-1:0]    WordCnt_out
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [PW-1:0] LAST_INIT = PW'(NREQ - 1);
    localparam logic [3:0]    CNT_LAST  = 4'(BURST_LEN - 1);

    logic [0:0]      state;
    logic [NREQ-1:0] gnt;
    logic [3:0]      cnt;
    logic [PW-1:0]   last_owner;

    logic [NREQ-1:0] ack;
    logic            accept;
    logic            owner_req;
    logic            burst_end;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;

    // Scan starts just past the previous owner, so the owner itself is checked last.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [PW-1:0]   last);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!res[PW] && req[idx]) begin
                res = {1'b1, PW'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        {win_found, win_idx} = rr_pick(Req_in, last_owner);
        for (int i = 0; i < NREQ; i++) begin
            if (win_found && (PW'(i) == win_idx)) begin
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Clear suppresses acceptance in its own cycle so the aborted word stays with its producer.
    assign ack       = gnt & Req_in & {NREQ{~Full_in & ~Clear_in}};
    assign accept    = |ack;
    assign owner_req = |(gnt & Req_in);
    assign burst_end = !Full_in && ((accept && (cnt == CNT_LAST)) || !owner_req);

    always_comb begin
        Data_out = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                Data_out = Data_out | Data_in[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            cnt        <= '0;
            last_owner <= LAST_INIT;
        end else if (Clear_in) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            cnt        <= '0;
            last_owner <= LAST_INIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state      <= ST_GRANT;
                        gnt        <= win_onehot;
                        last_owner <= win_idx;
                        cnt        <= '0;
                    end
                end
                ST_GRANT: begin
                    if (Full_in) begin
                        state <= ST_GRANT;
                    end else if (burst_end) begin
                        // Hand over in the same edge so consecutive bursts have no bubble.
                        if (win_found) begin
                            gnt        <= win_onehot;
                            last_owner <= win_idx;
                            cnt        <= '0;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                            cnt   <= '0;
                        end
                    end else if (accept) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign Gnt_out     = gnt;
    assign Ack_out     = ack;
    assign WriteEn_out = accept;
    assign Busy_out    = (state == ST_GRANT);

`ifdef FIFO_ARB_WORDCNT_EN
    logic [7:0] word_cnt [NREQ];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                word_cnt[i] <= '0;
            end
        end else if (Clear_in) begin
            for (int i = 0; i < NREQ; i++) begin
                word_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    word_cnt[i] <= word_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        WordCnt_out = '0;
        for (int i = 0; i < NREQ; i++) begin
            WordCnt_out[i*8 +: 8] = word_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DW=4, BURST_LEN=4).
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 4;
    localparam int BURST_LEN = 4;

    logic                Clk = 1'b0;
    logic                Reset_n;
    logic                Clear_in;
    logic [NREQ-1:0]     Req_in;
    logic [NREQ*DW-1:0]  Data_in;
    logic                Full_in;
    logic [NREQ-1:0]     Gnt_out;
    logic [NREQ-1:0]     Ack_out;
    logic                WriteEn_out;
    logic [DW-1:0]       Data_out;
    logic                Busy_out;
`ifdef FIFO_ARB_WORDCNT_EN
    logic [NREQ*8-1:0]   WordCnt_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(BURST_LEN)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Clear_in    (Clear_in),
        .Req_in      (Req_in),
        .Data_in     (Data_in),
        .Full_in     (Full_in),
        .Gnt_out     (Gnt_out),
        .Ack_out     (Ack_out),
        .WriteEn_out (WriteEn_out),
        .Data_out    (Data_out),
        .Busy_out    (Busy_out)
`ifdef FIFO_ARB_WORDCNT_EN
        ,
        .WordCnt_out (WordCnt_out)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_clear();
        Clear_in = 1'b1;
        Req_in   = '0;
        tick();
        Clear_in = 1'b0;
    endtask

    initial begin
        int exp_id;
        int wcount;
        Reset_n  = 1'b0;
        Clear_in = 1'b0;
        Full_in  = 1'b0;
        Req_in   = '0;
        Data_in  = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_gnt",  32'(Gnt_out), 32'h0);
        check("rst_busy", 32'(Busy_out), 32'h0);
        check("rst_we",   32'(WriteEn_out), 32'h0);
        Reset_n = 1'b1;

        // single requester, back-to-back re-grant
        Req_in  = 4'b0001;
        Data_in = 16'h0003;
        #1;
        check("t1_c0_gnt", 32'(Gnt_out), 32'h0);
        check("t1_c0_we",  32'(WriteEn_out), 32'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            Data_in = 16'(3 + k);
            #1;
            check("t1_gnt",  32'(Gnt_out), 32'h1);
            check("t1_we",   32'(WriteEn_out), 32'h1);
            check("t1_data", 32'(Data_out), 32'(3 + k));
            tick();
        end
        Req_in = '0;
        #1;
        check("t1_drop_we", 32'(WriteEn_out), 32'h0);
        tick();
        check("t1_idle_gnt",  32'(Gnt_out), 32'h0);
        check("t1_idle_busy", 32'(Busy_out), 32'h0);

        // round-robin fairness
        do_clear();
        Req_in  = 4'b1111;
        Data_in = 16'h3210;
        #1;
        check("t2_idle_we", 32'(WriteEn_out), 32'h0);
        tick();
        for (int k = 0; k < 17; k++) begin
            exp_id = (k / 4) % 4;
            check("t2_data", 32'(Data_out), 32'(exp_id));
            check("t2_we",   32'(WriteEn_out), 32'h1);
            check("t2_gnt",  32'(Gnt_out), 32'(1 << exp_id));
            tick();
        end
        do_clear();

        // back-pressure on requester 2
        Req_in  = 4'b0100;
        Data_in = 16'h0A00;
        #1;
        tick();
        Req_in  = 4'b0101;
        Data_in = 16'h0A05;
        #1;
        check("t3_gnt",  32'(Gnt_out), 32'h4);
        check("t3_ack",  32'(Ack_out), 32'h4);
        check("t3_data", 32'(Data_out), 32'hA);
        tick();
        check("t3_w2_we", 32'(WriteEn_out), 32'h1);
        tick();
        Full_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_stall_we",  32'(WriteEn_out), 32'h0);
            check("t3_stall_ack", 32'(Ack_out), 32'h0);
            check("t3_stall_gnt", 32'(Gnt_out), 32'h4);
            tick();
        end
        Full_in = 1'b0;
        wcount  = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (WriteEn_out) wcount++;
            check("t3_post_gnt", 32'(Gnt_out), 32'h4);
            tick();
        end
        check("t3_post_words", 32'(wcount), 32'd2);
        check("t3_next_gnt",   32'(Gnt_out), 32'h1);
        do_clear();

        // early release by requester 1, then requester 3
        Req_in  = 4'b1010;
        Data_in = 16'h3010;
        #1;
        tick();
        check("t4_g1_gnt",  32'(Gnt_out), 32'h2);
        check("t4_g1_ack",  32'(Ack_out), 32'h2);
        check("t4_g1_data", 32'(Data_out), 32'h1);
        tick();
        check("t4_g2_we", 32'(WriteEn_out), 32'h1);
        tick();
        Req_in = 4'b1000;
        #1;
        check("t4_drop_we",  32'(WriteEn_out), 32'h0);
        check("t4_drop_gnt", 32'(Gnt_out), 32'h2);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t4_r3_gnt",  32'(Gnt_out), 32'h8);
            check("t4_r3_we",   32'(WriteEn_out), 32'h1);
            check("t4_r3_data", 32'(Data_out), 32'h3);
            tick();
        end
        Req_in = '0;
        #1;
        check("t4_end_we", 32'(WriteEn_out), 32'h0);
        tick();
        check("t4_idle_gnt",  32'(Gnt_out), 32'h0);
        check("t4_idle_busy", 32'(Busy_out), 32'h0);

        // clear in the middle of requester 1's burst
        Req_in  = 4'b0010;
        Data_in = 16'h0010;
        #1;
        tick();
        check("t5_w1_we", 32'(WriteEn_out), 32'h1);
        tick();
        check("t5_w2_we", 32'(WriteEn_out), 32'h1);
        tick();
        Clear_in = 1'b1;
        Req_in   = 4'b1010;
        #1;
        check("t5_clr_ack", 32'(Ack_out), 32'h0);
        check("t5_clr_we",  32'(WriteEn_out), 32'h0);
        tick();
        Clear_in = 1'b0;
        #1;
        check("t5_after_gnt",  32'(Gnt_out), 32'h0);
        check("t5_after_busy", 32'(Busy_out), 32'h0);
        tick();
        check("t5_regnt", 32'(Gnt_out), 32'h2);
        do_clear();

`ifdef FIFO_ARB_WORDCNT_EN
        begin
            int n_acc;
            int cyc;
            n_acc = 0;
            cyc   = 0;
            Req_in  = 4'b0001;
            Data_in = 16'h0005;
            while (n_acc < 300 && cyc < 500) begin
                if (Ack_out[0]) n_acc++;
                tick();
                cyc++;
            end
            Req_in = '0;
            #1;
            check("t6_words",  32'(n_acc), 32'd300);
            check("t6_cnt0",   32'(WordCnt_out[7:0]), 32'd44);
            check("t6_others", 32'(WordCnt_out[31:8]), 32'h0);
            do_clear();
        end
`endif

        // asynchronous reset mid-burst
        Req_in = 4'b0001;
        tick();
        check("t7_pre_gnt", 32'(Gnt_out), 32'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("t7_rst_gnt",  32'(Gnt_out), 32'h0);
        check("t7_rst_busy", 32'(Busy_out), 32'h0);
        check("t7_rst_we",   32'(WriteEn_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's FIFO among NREQ producers.
- Grants one requester at a time, for a burst of up to BURST_LEN accepted words.
- Honours Full_in back-pressure and forwards the selected data and write enable to the FIFO.
- Sits in the FIFO write-clock domain; one clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, data width, matching the FIFO data width.
- BURST_LEN, 4, maximum words accepted per grant (1..15).

Ports:
- Clk  input  1  write-side clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Clear_in  input  1  synchronous clear: aborts the current grant and returns to IDLE.
- Req_in  input  NREQ  per-requester request; bit i is held high while requester i has a word on its data slice.
- Data_in  input  NREQ*DW  packed requester data; slice i = [i*DW +: DW].
- Full_in  input  1  FIFO full flag.
- Gnt_out  output  NREQ  registered one-hot grant; all zero in IDLE.
- Ack_out  output  NREQ  combinational per-requester word-accepted strobe.
- WriteEn_out  output  1  FIFO write enable.
- Data_out  output  DW  FIFO write data.
- Busy_out  output  1  high while in GRANT state.

Behaviour:
- Reset (Reset_n=0, async): state=IDLE, Gnt_out=0, burst count=0, last-owner pointer=NREQ-1 (so requester 0 wins first), Busy_out=0, WordCnt (if present)=0.
- Ack and write datapath (combinational):
  - Ack_out[i] = Gnt_out[i] & Req_in[i] & ~Full_in.
  - WriteEn_out = |Ack_out.
  - Data_out = Data_in slice of the granted requester; 0 when no grant.
- A word is accepted in the cycle Ack_out[i]=1. The requester must advance or drop its data at that edge.
- Arbitration function: scan Req_in starting at last_owner+1, modulo NREQ, and pick the first set bit. The current owner is therefore lowest priority.
- IDLE state:
  - If |Req_in at the edge: Gnt_out <= one-hot winner, last_owner <= winner, count <= 0, go to GRANT.
  - Grant latency is 1 cycle from request; the first write can occur in the first GRANT cycle.
- GRANT state, per edge:
  - Full_in=1: hold everything. No count change; stall cycles are unlimited.
  - Accept with count==BURST_LEN-1, or owner Req_in=0 (no accept): the burst ends. Re-arbitrate in the same edge over the current Req_in. If there is a winner, load the new grant with no bubble and set count <= 0. Otherwise go to IDLE and set Gnt_out <= 0.
  - Accept otherwise: count <= count+1.
- Owner rule: owner dropping Req mid-burst ends the grant immediately. Words are never accepted from a non-granted requester.
- Single requester: it is re-granted back-to-back. Each burst still closes after BURST_LEN words; count resets with no idle cycle.
- Clear_in=1 (synchronous, overrides all): Ack_out and WriteEn_out are forced to 0 in that cycle. Gnt_out <= 0, state <= IDLE, count <= 0, last_owner <= NREQ-1.
- Reset_n low mid-burst: all outputs drop asynchronously. Words not yet acked are the requesters' responsibility.
- Width rules:
  - Count is 4 bits.
  - Pointer width is clog2(NREQ).
  - Busy_out = (state==GRANT).

Optional Feature:
- Macro FIFO_ARB_WORDCNT_EN.
- When defined: adds output WordCnt_out, width NREQ*8. Slice i is an 8-bit wrapping count of words accepted from requester i. It increments on Ack_out[i], wraps 255->0, and clears on reset or Clear_in.
- When undefined: the port and counters are absent. Other behaviour is identical.

Test Plan:
- Reset then single request: Req_in=4'b0001 from cycle 0 with data 3,4,5,6,7, Full_in=0 -> Gnt_out=0001 from cycle 1. Writes 3,4,5,6 on cycles 1-4, then re-grant to requester 0, and 7 is written on cycle 5.
- Round-robin fairness: Req_in=4'b1111 held, each requester supplies its own ID as data -> Data_out is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., with no idle cycle between bursts.
- Back-pressure: requester 2 granted, Full_in=1 for 5 cycles after its 2nd word -> WriteEn_out=0 and Ack_out=0 during the stall. Gnt_out stays 0100, and exactly 2 more words are written after Full_in falls.
- Early release: requester 1 drops Req after 2 words while requester 3 is requesting -> Gnt_out moves 0010->1000 on the next edge. Requester 3 writes 4 words, then the FSM goes to IDLE with Gnt_out=0 and Busy_out=0 if no requests remain.
- Clear mid-burst: Clear_in pulsed during requester 1's 3rd word -> that word is not acked and WriteEn_out=0 in that cycle. Next cycle Gnt_out=0, and the following grant goes to the lowest set Req starting from 0.
- With FIFO_ARB_WORDCNT_EN: 300 words accepted from requester 0 -> WordCnt_out[7:0]=44, and other slices stay 0.
